// File: rtl/sram_fifo_pkg.sv
// Shared types for the SRAM FIFO read-side adapter.
// Occupancy encoding and output-buffer depth.
package sram_fifo_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/sram_fifo_fwft_adapter.sv
// FWFT valid/ready adapter over a registered-read SRAM FIFO.
// Optional delivered-word counter: define SRAM_FIFO_FWFT_CNT_EN.
module sram_fifo_fwft_adapter
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rden_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  valid_o,
  input  logic                  ready_i,
`ifdef SRAM_FIFO_FWFT_CNT_EN
  output logic [31:0]           xfer_cnt_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o
);

  occ_e                  occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  pop;
  logic                  arrive;
  logic [2:0]            credit;

  assign valid_o = (occ != OCC_EMPTY);
  assign data_o  = buf0;
  assign pop     = valid_o & ready_i;
  assign arrive  = inflight;

  // Slots claimed after this cycle's pop; a new read needs one free.
  assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  assign fifo_rden_o = rst_n & ~fifo_empty_i
                     & (credit < 3'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= OCC_EMPTY;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_rden_o;
      unique case (occ)
        OCC_EMPTY: begin
          if (arrive) begin
            buf0 <= fifo_rdata_i;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (arrive && !pop) begin
            buf1 <= fifo_rdata_i;
            occ  <= OCC_TWO;
          end else if (pop && !arrive) begin
            occ  <= OCC_EMPTY;
          end else if (pop && arrive) begin
            buf0 <= fifo_rdata_i;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            buf0 <= buf1;
            if (arrive) buf1 <= fifo_rdata_i;
            else        occ  <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

`ifdef SRAM_FIFO_FWFT_CNT_EN
  logic [31:0] xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   xfer_cnt <= '0;
    else if (pop) xfer_cnt <= xfer_cnt + 32'd1;
  end

  assign xfer_cnt_o = xfer_cnt;
`endif

endmodule

// File: tb/tb_sram_fifo_fwft_adapter.sv
// Directed bench for sram_fifo_fwft_adapter with a behavioural
// registered-read FIFO model on the upstream side.
module tb_sram_fifo_fwft_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_rden;
  logic [31:0] fifo_rdata;
  logic        valid;
  logic        ready;
  logic [31:0] data;
`ifdef SRAM_FIFO_FWFT_CNT_EN
  logic [31:0] xfer_cnt;
`endif

  logic [31:0] mem [0:63];
  int          wptr;
  int          rptr;
  logic        fifo_clr;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          nrden  = 0;
  logic        underflow = 1'b0;
  logic        occ_bad   = 1'b0;
  logic [31:0] got [$];
  int          popcyc [$];

  always #5 clk = ~clk;

  sram_fifo_fwft_adapter #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_rden_o  (fifo_rden),
    .fifo_rdata_i (fifo_rdata),
    .valid_o      (valid),
    .ready_i      (ready),
`ifdef SRAM_FIFO_FWFT_CNT_EN
    .xfer_cnt_o   (xfer_cnt),
`endif
    .data_o       (data)
  );

  assign fifo_empty = (wptr == rptr);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rptr <= 0;
    end else if (fifo_rden) begin
      fifo_rdata <= mem[rptr & 63];
      rptr       <= rptr + 1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rden) nrden <= nrden + 1;
    if (fifo_rden && fifo_empty) underflow <= 1'b1;
    if (valid && ready) begin
      got.push_back(data);
      popcyc.push_back(cyc);
    end
    if (dut.occ > 2'd2) occ_bad <= 1'b1;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [31:0] d);
    mem[wptr & 63] = d;
    wptr++;
  endtask

  task automatic chk_seq(string tag, int n, logic [31:0] base);
    chk({tag, "_cnt"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = (i < got.size()) ? got[i] : 32'hDEAD_DEAD;
      chk(tag, w, base + i);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ready    = 1'b0;
    wptr     = 0;
    rptr     = 0;
    fifo_clr = 1'b1;
    fifo_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_rden", fifo_rden, 0);
`ifdef SRAM_FIFO_FWFT_CNT_EN
    chk("rst_cnt", xfer_cnt, 0);
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    fifo_clr = 1'b0;

    // prefetch latency: empty falls in N, valid in N+2
    @(negedge clk);
    nrden = 0;
    push(32'hA5A5_0001);
    ready = 1'b1;
    #1 chk("lat_rden_n", fifo_rden, 1);
    @(negedge clk);
    #1 chk("lat_valid_n1", valid, 0);
    chk("lat_rden_n1", fifo_rden, 0);
    @(negedge clk);
    #1 chk("lat_valid_n2", valid, 1);
    chk("lat_data_n2", data, 32'hA5A5_0001);
    @(negedge clk);
    #1 chk("lat_valid_n3", valid, 0);
    chk("lat_rden_cnt", nrden, 1);

    // streaming with ready held high
    @(negedge clk);
    got.delete();
    popcyc.delete();
    for (int i = 1; i <= 16; i++) push(i);
    repeat (20) @(negedge clk);
    #1 chk_seq("stream", 16, 1);
    chk("stream_gapless", popcyc[15] - popcyc[0], 15);
    chk("stream_underflow", underflow, 0);
    chk("stream_idle", valid, 0);
`ifdef SRAM_FIFO_FWFT_CNT_EN
    chk("stream_cnt", xfer_cnt, 17);
`endif

    // backpressure: two words prefetched then hold
    @(negedge clk);
    ready = 1'b0;
    nrden = 0;
    got.delete();
    for (int i = 1; i <= 8; i++) push(i);
    repeat (4) @(negedge clk);
    #1 chk("bp_valid_a", valid, 1);
    chk("bp_data_a", data, 1);
    repeat (6) @(negedge clk);
    #1 chk("bp_rden_cnt", nrden, 2);
    chk("bp_valid_b", valid, 1);
    chk("bp_data_b", data, 1);
    chk("bp_rden_off", fifo_rden, 0);
    ready = 1'b1;
    #1 chk("bp_rden_same", fifo_rden, 1);
    repeat (12) @(negedge clk);
    #1 chk_seq("bp", 8, 1);

    // alternating ready
    @(negedge clk);
    got.delete();
    for (int i = 1; i <= 16; i++) push(i);
    for (int k = 0; k < 40; k++) begin
      ready = (k % 2 == 0);
      @(negedge clk);
    end
    ready = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk_seq("alt", 16, 1);
    chk("alt_occ", occ_bad, 0);
    chk("alt_underflow", underflow, 0);

    // reset with occ=ONE and a word in flight
    @(negedge clk);
    ready = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) push(32'h11 + i);
    @(negedge clk);
    @(negedge clk);
    #1 chk("mid_valid_pre", valid, 1);
    rst_n    = 1'b0;
    wptr     = 0;
    fifo_clr = 1'b1;
    #1 chk("mid_valid", valid, 0);
    chk("mid_rden", fifo_rden, 0);
    chk("mid_data", data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    fifo_clr = 1'b0;
    ready    = 1'b1;
    repeat (5) @(negedge clk);
    #1 chk("mid_stale_cnt", got.size(), 0);
    chk("mid_stale_valid", valid, 0);
    push(32'hBEEF);
    repeat (4) @(negedge clk);
    #1 chk_seq("mid_after", 1, 32'hBEEF);

`ifdef SRAM_FIFO_FWFT_CNT_EN
    chk("cnt_after_rst", xfer_cnt, 1);
    force dut.xfer_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.xfer_cnt;
    push(32'h77);
    repeat (4) @(negedge clk);
    #1 chk("cnt_wrap", xfer_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
